bcd_to_bin: RTL and testbench
=============================

# bcd_to_bin

Sequential BCD-to-binary converter using reverse double dabble: shift right, then subtract 3 from any BCD digit ≥ 8. It is the return path for the binary-to-BCD converter. It accepts packed BCD, for example from a keypad or digit-entry front end, and produces the binary value for downstream arithmetic. Conversion is multi-cycle and serial, one digit adjustment per cycle, trading latency for area. Results are signalled with a one-cycle `rdy` pulse.

## Interface
- `DIGITS`, default 4: number of BCD digits in the input.
- `BIN_W`, default 14: binary output width. Must satisfy 10^DIGITS − 1 < 2^BIN_W.
- `clk`  in  1: the only clock; all logic is on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `en`  in  1: start request, sampled only in IDLE.
- `bcd_d_in`  in  4*DIGITS: packed BCD, digit 0 in bits [3:0]. Captured in SETUP.
- `bin_d_out`  out  BIN_W: conversion result; held until the next DONE.
- `rdy`  out  1: one-cycle pulse when `bin_d_out`/`err` update.
- `err`  out  1: set with `rdy` if any input digit > 9; held until the next DONE.

## Operation
- FSM states:
  - IDLE: if `en`=1, go to SETUP; otherwise stay.
  - SETUP: load work register {bcd[4*DIGITS-1:0], bin[BIN_W-1:0]} ← {`bcd_d_in`, 0}. Clear shift counter and digit index. If any digit > 9, set the error flag and go to DONE; otherwise go to SHIFT.
  - SHIFT: logical right shift of the whole work register by 1 (bcd LSB moves into bin MSB). Increment shift counter. Go to SUB with digit index 0.
  - SUB: if work digit[idx] ≥ 8, subtract 3 (4-bit, no borrow into the neighbour). Then:
    - idx < DIGITS−1: idx++ and stay in SUB.
    - otherwise, if shift count < BIN_W: go to SHIFT.
    - otherwise: go to DONE.
  - DONE: `bin_d_out` ← bin field (or 0 if error), `err` ← error flag, `rdy` ← 1, go to IDLE.
- `bcd_d_in` is only sampled in SETUP; it may change freely at any other time.
- `en` is ignored outside IDLE, with no queuing. `en` held high continuously restarts a conversion on each visit to IDLE.
- After BIN_W shifts the bcd field is 0 for any valid input. The bin field then equals the decimal value.
- Counters: shift counter is $clog2(BIN_W+1) bits; digit index is $clog2(DIGITS) bits, minimum 1.

## Timing
- Reset state: FSM=IDLE, `bin_d_out`=0, `rdy`=0, `err`=0, work register and counters 0.
- Reset mid-conversion aborts immediately with no `rdy` pulse. The next `en` in IDLE starts a fresh conversion.
- Valid-input latency: `rdy` is high in cycle 2 + BIN_W*(DIGITS+1) after the edge that samples `en`. With defaults that is 72 cycles.
- Invalid-input latency: `rdy`/`err` high 2 cycles after the `en` sample edge.
- `rdy` is high for exactly one cycle. `bin_d_out` and `err` change only on that same edge.
- Earliest restart: `en` sampled in the cycle after `rdy`, since the FSM is then back in IDLE.
- `rst` and `en` high in the same cycle: reset wins.

## Structure
- Shared package `bcd_pkg`:
  - state enum `bcd2bin_state_t` (IDLE, SETUP, SHIFT, SUB, DONE);
  - localparam `BCD_DIGIT_W` = 4;
  - the same state encoding used by the binary-to-BCD converter.
- Sub-module `bcd_digit_sub3`: combinational 4-bit in/out, returns d−3 if d ≥ 8 else d. Instantiated once, fed by the digit multiplexer on idx.
- Top level holds the FSM, work register, counters and the invalid-digit detector (DIGITS comparators OR-reduced).

## Test plan
- Reset → 0: after reset, `en` with `bcd_d_in`=16'h0000 → `rdy` at cycle 72, `bin_d_out`=14'd0, `err`=0.
- Maximum value: 16'h9999 → `bin_d_out`=14'h270F (9999) at cycle 72. Also 16'h4095 → 14'h0FFF.
- Invalid digit: 16'h12A4 → `rdy` at cycle 2, `err`=1, `bin_d_out`=0. A following valid 16'h0010 → 10, `err`=0.
- Busy ignore: pulse `en` with 16'h0001 at cycles 5 and 30 of a 16'h0123 conversion → exactly one `rdy`, result 123. Changing `bcd_d_in` after SETUP has no effect.
- Reset mid-operation: assert `rst` at cycle 40 of a 16'h5000 conversion → no `rdy`, outputs 0. The next conversion of 16'h0042 → 42.
- Round trip: every 0..4095 through the binary-to-BCD converter, then this block → output equals the original value. `rdy` is a single-cycle pulse each time.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD conversion blocks (binary-to-BCD and
// BCD-to-binary). Both converters use the same FSM state encoding.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    SUB   = 3'd3,
    DONE  = 3'd4
  } bcd2bin_state_t;

  // A BCD digit is malformed when it encodes a value above nine.
  function automatic logic digit_invalid(input logic [BCD_DIGIT_W-1:0] d);
    return (d > 4'd9);
  endfunction

endpackage

// File: rtl/bcd_digit_sub3.sv
// Reverse double-dabble digit correction: a BCD digit that reads 8 or more
// after a right shift has absorbed a half-ten from its upper neighbour, so
// 3 is removed to restore a proper decimal weighting.
module bcd_digit_sub3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);

  // Conditional subtract-3, confined to the 4-bit digit (no borrow out).
  always_comb begin
    q = d;
    if (d >= 4'd8) begin
      q = d - 4'd3;
    end else begin
      q = d;
    end
  end

endmodule

// File: rtl/bcd_to_bin.sv
// Serial BCD-to-binary converter (reverse double dabble). One shift of the
// combined {bcd, bin} work register, followed by one digit correction per
// cycle. A single correction unit is shared across the digits via idx.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_d_in,
  output logic [BIN_W-1:0]            bin_d_out,
  output logic                        rdy,
  output logic                        err
);

  localparam int BCD_W  = BCD_DIGIT_W * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  bcd2bin_state_t           state_r;
  logic [WORK_W-1:0]        work_r;
  logic [CNT_W-1:0]         shift_cnt_r;
  logic [IDX_W-1:0]         idx_r;
  logic                     err_flag_r;

  logic                     any_bad_s;
  logic [BCD_DIGIT_W-1:0]   digit_sel_s;
  logic [BCD_DIGIT_W-1:0]   digit_fix_s;

  // Invalid-digit detector: one comparator per input digit, OR-reduced.
  always_comb begin
    any_bad_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_invalid(bcd_d_in[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
        any_bad_s = 1'b1;
      end else begin
        any_bad_s = any_bad_s;
      end
    end
  end

  // Digit multiplexer feeding the shared correction unit.
  always_comb begin
    digit_sel_s = work_r[BIN_W + BCD_DIGIT_W*int'(idx_r) +: BCD_DIGIT_W];
  end

  bcd_digit_sub3 u_sub3 (
    .d (digit_sel_s),
    .q (digit_fix_s)
  );

  // Conversion FSM with work register, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      work_r      <= {WORK_W{1'b0}};
      shift_cnt_r <= {CNT_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      err_flag_r  <= 1'b0;
      bin_d_out   <= {BIN_W{1'b0}};
      rdy         <= 1'b0;
      err         <= 1'b0;
    end else begin
      rdy <= 1'b0;
      case (state_r)
        IDLE: begin
          if (en) begin
            state_r <= SETUP;
          end else begin
            state_r <= IDLE;
          end
        end
        SETUP: begin
          work_r      <= {bcd_d_in, {BIN_W{1'b0}}};
          shift_cnt_r <= {CNT_W{1'b0}};
          idx_r       <= {IDX_W{1'b0}};
          err_flag_r  <= any_bad_s;
          if (any_bad_s) begin
            state_r <= DONE;
          end else begin
            state_r <= SHIFT;
          end
        end
        SHIFT: begin
          // bcd LSB falls into bin MSB; a zero enters at the top
          work_r      <= work_r >> 1;
          shift_cnt_r <= shift_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          idx_r       <= {IDX_W{1'b0}};
          state_r     <= SUB;
        end
        SUB: begin
          work_r[BIN_W + BCD_DIGIT_W*int'(idx_r) +: BCD_DIGIT_W] <= digit_fix_s;
          if (idx_r != IDX_W'(DIGITS - 1)) begin
            idx_r   <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            state_r <= SUB;
          end else if (shift_cnt_r < CNT_W'(BIN_W)) begin
            state_r <= SHIFT;
          end else begin
            state_r <= DONE;
          end
        end
        DONE: begin
          if (err_flag_r) begin
            bin_d_out <= {BIN_W{1'b0}};
          end else begin
            bin_d_out <= work_r[BIN_W-1:0];
          end
          err     <= err_flag_r;
          rdy     <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin (DIGITS=4, BIN_W=14) against a
// decimal-arithmetic reference model.
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [15:0] bcd_d_in = 16'h0000;
  logic [13:0] bin_d_out;
  logic        rdy;
  logic        err;

  int total = 0;
  int bad   = 0;

  bcd_to_bin #(.DIGITS(4), .BIN_W(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .bcd_d_in  (bcd_d_in),
    .bin_d_out (bin_d_out),
    .rdy       (rdy),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference: value of the decimal digits, or error when any digit > 9.
  function automatic void ref_conv(input logic [15:0] b, output int val, output bit inval);
    int w;
    val = 0; inval = 0; w = 1;
    for (int i = 0; i < 4; i++) begin
      int d;
      d = (b >> (4*i)) & 15;
      if (d > 9) inval = 1;
      val += d * w;
      w *= 10;
    end
    if (inval) val = 0;
  endfunction

  // Binary-to-BCD encoding of a value 0..9999 (the forward converter's role).
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      r = r | 16'((v % 10) << (4*i));
      v = v / 10;
    end
    return r;
  endfunction

  // Start one conversion; observe until 'post' cycles after the first rdy.
  task automatic run_conv(input logic [15:0] b, input int post, input bit busy,
                          input bit scramble, output int lat, output logic [13:0] bo,
                          output logic eo, output int nrdy, output bit held);
    logic [13:0] b0;
    logic        e0;
    @(negedge clk);
    b0 = bin_d_out; e0 = err;
    bcd_d_in = b; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    lat = -1; nrdy = 0; held = 1; bo = 14'd0; eo = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (busy && (c == 5 || c == 30)) begin
        en = 1'b1; bcd_d_in = 16'h0001;
      end else begin
        en = 1'b0;
      end
      if (scramble && c >= 2) bcd_d_in = 16'($urandom);
      @(posedge clk); #1;
      if (rdy) begin
        nrdy++;
        if (lat < 0) begin lat = c; bo = bin_d_out; eo = err; end
      end else if (lat < 0 && (bin_d_out !== b0 || err !== e0)) begin
        held = 0;
      end
      if (lat >= 0 && c >= lat + post) break;
    end
    en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bin_d_out !== 14'd0) begin bad++; $display("FAIL reset_bin got=%0d want=0", bin_d_out); end
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b want=0", rdy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    en = 1'b0; rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL reset_en_ignored rdy=%b want=0", rdy); end
  endtask

  task automatic test_directed();
    logic [15:0] vec [4] = '{16'h0000, 16'h9999, 16'h4095, 16'h0010};
    int lat, nrdy, val; logic [13:0] bo; logic eo; bit held, inval;
    for (int i = 0; i < 4; i++) begin
      ref_conv(vec[i], val, inval);
      run_conv(vec[i], 3, 0, 0, lat, bo, eo, nrdy, held);
      total++; if (lat !== 72) begin bad++; $display("FAIL dir_latency bcd=%h got=%0d want=72", vec[i], lat); end
      total++; if (bo !== 14'(val)) begin bad++; $display("FAIL dir_value bcd=%h got=%0d want=%0d", vec[i], bo, val); end
      total++; if (eo !== 1'b0) begin bad++; $display("FAIL dir_err bcd=%h got=%b want=0", vec[i], eo); end
      total++; if (nrdy !== 1) begin bad++; $display("FAIL dir_rdy_pulses bcd=%h got=%0d want=1", vec[i], nrdy); end
      total++; if (!held) begin bad++; $display("FAIL dir_hold bcd=%h outputs changed before rdy", vec[i]); end
    end
  endtask

  task automatic test_invalid();
    int lat, nrdy; logic [13:0] bo; logic eo; bit held;
    run_conv(16'h12A4, 3, 0, 0, lat, bo, eo, nrdy, held);
    total++; if (lat !== 2) begin bad++; $display("FAIL inv_latency got=%0d want=2", lat); end
    total++; if (eo !== 1'b1) begin bad++; $display("FAIL inv_err got=%b want=1", eo); end
    total++; if (bo !== 14'd0) begin bad++; $display("FAIL inv_value got=%0d want=0", bo); end
    total++; if (nrdy !== 1) begin bad++; $display("FAIL inv_rdy_pulses got=%0d want=1", nrdy); end
    run_conv(16'h0010, 1, 0, 0, lat, bo, eo, nrdy, held);
    total++; if (bo !== 14'd10 || eo !== 1'b0) begin bad++; $display("FAIL inv_recover got=%0d/%b want=10/0", bo, eo); end
  endtask

  task automatic test_busy_ignore();
    int lat, nrdy; logic [13:0] bo; logic eo; bit held;
    run_conv(16'h0123, 40, 1, 1, lat, bo, eo, nrdy, held);
    total++; if (nrdy !== 1) begin bad++; $display("FAIL busy_rdy_count got=%0d want=1", nrdy); end
    total++; if (lat !== 72) begin bad++; $display("FAIL busy_latency got=%0d want=72", lat); end
    total++; if (bo !== 14'd123) begin bad++; $display("FAIL busy_value got=%0d want=123", bo); end
  endtask

  task automatic test_reset_mid();
    int seen, lat, nrdy; logic [13:0] bo; logic eo; bit held, nonzero;
    seen = 0; nonzero = 0;
    @(negedge clk);
    bcd_d_in = 16'h5000; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    for (int c = 1; c <= 120; c++) begin
      rst = (c == 40);
      @(posedge clk); #1;
      if (rdy) seen++;
      if (c >= 40 && (bin_d_out !== 14'd0 || err !== 1'b0)) nonzero = 1;
    end
    rst = 1'b0;
    total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_rdy got=%0d want=0", seen); end
    total++; if (nonzero) begin bad++; $display("FAIL rstmid_outputs got=%0d/%b want=0/0", bin_d_out, err); end
    run_conv(16'h0042, 1, 0, 0, lat, bo, eo, nrdy, held);
    total++; if (bo !== 14'd42 || lat !== 72) begin bad++; $display("FAIL rstmid_next got=%0d lat=%0d want=42 lat=72", bo, lat); end
  endtask

  task automatic test_back_to_back();
    int r1, r2; logic [13:0] v1;
    r1 = -1; r2 = -1; v1 = 14'd0;
    @(negedge clk);
    bcd_d_in = 16'h0042; en = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (rdy && r1 < 0) begin r1 = c; v1 = bin_d_out; end
      else if (rdy && r2 < 0) r2 = c;
      if (r2 >= 0) break;
    end
    en = 1'b0;
    total++; if (r1 !== 72 || v1 !== 14'd42) begin bad++; $display("FAIL b2b_first got=%0d@%0d want=42@72", v1, r1); end
    total++; if (r2 !== 145) begin bad++; $display("FAIL b2b_restart got=%0d want=145", r2); end
    repeat (5) @(posedge clk);
  endtask

  task automatic test_random();
    int lat, nrdy, val, wl; logic [13:0] bo; logic eo; bit held, inval;
    logic [15:0] b;
    for (int n = 0; n < 150; n++) begin
      if (n == 0) b = to_bcd(4095);
      else if (n % 4 == 3) b = 16'($urandom);
      else b = to_bcd($urandom_range(0, 4095));
      ref_conv(b, val, inval);
      wl = inval ? 2 : 72;
      run_conv(b, 1, 0, n % 2, lat, bo, eo, nrdy, held);
      total++;
      if (lat !== wl || bo !== 14'(val) || eo !== inval || nrdy !== 1 || !held) begin
        bad++;
        $display("FAIL rand bcd=%h got=%0d err=%b lat=%0d n=%0d want=%0d err=%b lat=%0d n=1",
                 b, bo, eo, lat, nrdy, val, inval, wl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_invalid();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
